// File: rtl/carryskip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : carryskip_pkg
// Description : Command codes, FSM states and sizing helper for the
//               carry-skip host interface.
// Revision    : 1.0  initial release
// ============================================================================
package carryskip_pkg;

   localparam logic [1:0] CMD_LOAD_A = 2'b00;
   localparam logic [1:0] CMD_LOAD_B = 2'b01;
   localparam logic [1:0] CMD_START  = 2'b10;
   localparam logic [1:0] CMD_READ   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int num_blk(input int nbytes, input int block);
      return (8 * nbytes) / block;
   endfunction

endpackage
`default_nettype wire

// File: rtl/carryskip_host_if_if.sv
`default_nettype none
// ============================================================================
// Module      : carryskip_host_if_if
// Description : Command/response bundle between the pin driver and the
//               carry-skip host responder.
// Revision    : 1.0  initial release
// ============================================================================
interface carryskip_host_if_if;

   logic       ena;
   logic [7:0] in_data;
   logic [1:0] in_cmd;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       busy;
   logic       done;
   logic       cout;
   logic [7:0] skip_cnt;

   modport master (
      output ena, in_data, in_cmd, in_valid,
      input  in_ready, out_data, out_valid, busy, done, cout, skip_cnt
   );

   modport slave (
      input  ena, in_data, in_cmd, in_valid,
      output in_ready, out_data, out_valid, busy, done, cout, skip_cnt
   );

endinterface
`default_nettype wire

// File: rtl/carryskip_block.sv
`default_nettype none
// ============================================================================
// Module      : carryskip_block
// Description : One BLOCK-bit carry-skip slice: sum, propagate and the
//               carry that leaves the slice (bypassed when propagate is set).
// Revision    : 1.0  initial release
// ============================================================================
module carryskip_block #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] s,
   output logic             p,
   output logic             cout_skip
);

   logic w_g;

   assign {w_g, s}  = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, cin};
   assign p         = &(a ^ b);
   // A fully propagating slice always forwards cin, so the bypass equals the ripple carry.
   assign cout_skip = p ? cin : w_g;

endmodule
`default_nettype wire

// File: rtl/carryskip_host_if.sv
`default_nettype none
// ============================================================================
// Module      : carryskip_host_if
// Description : Byte-serial host responder running a multi-cycle carry-skip
//               addition, one skip block per clock, with read-back.
// Revision    : 1.0  initial release
// ============================================================================
module carryskip_host_if
   import carryskip_pkg::*;
#(
   parameter int NBYTES = 4,
   parameter int BLOCK  = 4
) (
   input  logic                clk,
   input  logic                rst,
   carryskip_host_if_if.slave  bus
);

   localparam int W       = 8 * NBYTES;
   localparam int NUM_BLK = num_blk(NBYTES, BLOCK);
   localparam int BLK_W   = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
   localparam int IDX_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_t             r_state;
   logic [W-1:0]       r_a;
   logic [W-1:0]       r_b;
   logic [W-1:0]       r_s;
   logic               r_carry;
   logic [BLK_W-1:0]   r_blk;
   logic [7:0]         r_skip_cnt;
   logic               r_cout;
   logic               r_done;
   logic               r_busy;
   logic [7:0]         r_out_data;
   logic               r_out_valid;

   logic               w_ready;
   logic               w_accept;
   logic [W-1:0]       w_a_shift;
   logic [W-1:0]       w_b_shift;
   logic [IDX_W-1:0]   w_rd_idx;
   logic [7:0]         w_rd_byte;
   logic [BLOCK-1:0]   w_blk_a;
   logic [BLOCK-1:0]   w_blk_b;
   logic [BLOCK-1:0]   w_blk_s;
   logic               w_blk_p;
   logic               w_blk_cout;
   logic               w_last_blk;

   assign w_ready  = bus.ena & (r_state != ST_ADD);
   assign w_accept = bus.in_valid & w_ready;

   // New byte enters at the top so the first byte loaded ends up as the LSB.
   assign w_a_shift = (r_a >> 8) | (W'(bus.in_data) << (W - 8));
   assign w_b_shift = (r_b >> 8) | (W'(bus.in_data) << (W - 8));

   assign w_rd_idx = bus.in_data[IDX_W-1:0];

   always_comb begin
      w_rd_byte = 8'h00;
      for (int i = 0; i < NBYTES; i++) begin
         if (w_rd_idx == IDX_W'(i)) begin
            w_rd_byte = r_s[i*8 +: 8];
         end
      end
   end

   assign w_blk_a    = r_a[int'(r_blk)*BLOCK +: BLOCK];
   assign w_blk_b    = r_b[int'(r_blk)*BLOCK +: BLOCK];
   assign w_last_blk = (r_blk == BLK_W'(NUM_BLK - 1));

   carryskip_block #(
      .BLOCK     (BLOCK)
   ) u_block (
      .a         (w_blk_a),
      .b         (w_blk_b),
      .cin       (r_carry),
      .s         (w_blk_s),
      .p         (w_blk_p),
      .cout_skip (w_blk_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_s         <= '0;
         r_carry     <= 1'b0;
         r_blk       <= '0;
         r_skip_cnt  <= 8'h00;
         r_cout      <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_out_data  <= 8'h00;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_accept) begin
                  case (bus.in_cmd)
                     CMD_LOAD_A: r_a <= w_a_shift;
                     CMD_LOAD_B: r_b <= w_b_shift;
                     CMD_START: begin
                        r_carry    <= bus.in_data[0];
                        r_blk      <= '0;
                        r_skip_cnt <= 8'h00;
                        r_s        <= '0;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_ADD;
                     end
                     CMD_READ: begin
                        r_out_data  <= w_rd_byte;
                        r_out_valid <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            ST_ADD: begin
               r_s[int'(r_blk)*BLOCK +: BLOCK] <= w_blk_s;
               r_carry <= w_blk_cout;
               if (w_blk_p && (r_skip_cnt != 8'hFF)) begin
                  r_skip_cnt <= r_skip_cnt + 8'd1;
               end
               if (w_last_blk) begin
                  r_cout  <= w_blk_cout;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_DONE;
               end else begin
                  r_blk <= r_blk + BLK_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.cout      = r_cout;
   assign bus.skip_cnt  = r_skip_cnt;

endmodule
`default_nettype wire

// File: doc/carryskip_host_if.md
Name: carryskip_host_if

Overview:
- Host-side responder for the carry-skip adder tile; the tile top wires it between the TT pins and the arithmetic.
- Receives byte-serial operands and commands from the external driver (ui_in data, uio_in control).
- Performs a multi-cycle carry-skip addition, one skip block per clock.
- Returns result bytes, carry-out and a skip statistic on the output pins.

Parameters:
- NBYTES, 4, operand width in bytes (operand width W = 8*NBYTES).
- BLOCK, 4, carry-skip block width in bits. W must be divisible by BLOCK. NUM_BLK = W/BLOCK.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- ena  input  1  tile enable; gates command acceptance only.
- in_data  input  8  operand byte, carry-in (bit0) or read index.
- in_cmd  input  2  command: 00 LOAD_A, 01 LOAD_B, 10 START, 11 READ.
- in_valid  input  1  command strobe.
- in_ready  output  1  command accepted when in_valid & in_ready.
- out_data  output  8  read-back byte.
- out_valid  output  1  one-cycle pulse qualifying out_data.
- busy  output  1  addition in progress.
- done  output  1  result valid; held until next START or reset.
- cout  output  1  carry-out of last addition.
- skip_cnt  output  8  number of blocks in last addition whose carry bypassed the block.

Behaviour:
- One clock. Reset is synchronous and active-high. All registers update on the rising edge of clk.
- Reset: state IDLE. Registers A, B and S clear to 0. out_data=0, out_valid=0, busy=0, done=0, cout=0, skip_cnt=0.
- Reset asserted during ADD aborts the addition and clears the partial result.
- States: IDLE, ADD, DONE.
- in_ready = ena & (state != ADD). Commands arriving while busy or while ena=0 are dropped; no queuing.
- LOAD_A / LOAD_B, accepted in IDLE or DONE:
  - A (or B) shifts right by 8 bits; in_data enters the top byte.
  - After NBYTES loads, the first byte loaded sits in the LSB position.
  - Loading does not change the state or done.
- START, accepted in IDLE or DONE:
  - Latch carry = in_data[0]; blk = 0; clear skip_cnt, S and done; go to ADD.
- ADD, one block per cycle, block i = bits [i*BLOCK +: BLOCK]:
  - p = &(a_i ^ b_i).
  - {g, s_i} = a_i + b_i + carry.
  - S block i <= s_i.
  - carry <= p ? carry : g. The result equals the ripple carry; the bypass path is what the block models.
  - If p, skip_cnt increments, saturating at 255.
  - After block NUM_BLK-1: cout <= carry, state DONE, done = 1.
- Timing: START accepted at edge T gives busy=1 for cycles T+1 .. T+NUM_BLK, and done=1, busy=0 from T+NUM_BLK+1. Default latency is 8 cycles.
- READ, accepted in IDLE or DONE:
  - out_data <= S byte at index in_data[$clog2(NBYTES)-1:0]. Index values >= NBYTES return 0.
  - out_valid = 1 for exactly the next cycle, then 0.
  - out_data holds its value until the next READ.
  - READ in IDLE after reset returns 0.
- Wrap-around: the sum is modulo 2^W and cout carries bit W. Back-to-back START is allowed from DONE and restarts cleanly.

Decomposition:
- Package carryskip_pkg holds:
  - the command encoding constants CMD_LOAD_A, CMD_LOAD_B, CMD_START, CMD_READ;
  - the state enum typedef;
  - the NUM_BLK helper function.
- One sub-module, carryskip_block: combinational BLOCK-bit slice with inputs a, b, cin and outputs s, p, cout_skip. It is instantiated once and indexed by blk, so the slice hardware is time-shared rather than replicated.

Test Plan:
- Load A=0x0000FFFF, B=0x00000001, START with cin=0 -> after 8 busy cycles: done=1, cout=0, skip_cnt=3; READ indices 0..3 return 0x00, 0x00, 0x01, 0x00.
- Load A=0xFFFFFFFF, B=0x00000000, START with cin=1 -> S=0x00000000, cout=1, skip_cnt=8.
- Load A=0x12345678, B=0x9ABCDEF0, cin=0 -> S=0xACF13568, cout=0, skip_cnt=0. READ index 2 -> out_data=0xF1 with a single-cycle out_valid.
- During ADD, issue LOAD_A 0xAA and START -> in_ready=0, commands dropped; result and A unchanged versus the no-interference run.
- Assert rst at busy cycle 4 -> next cycle busy=0, done=0, skip_cnt=0; READ of every index returns 0x00.
- ena=0 with in_valid=1 for a LOAD_A and a START -> no state change. With ena=1, the same sequence is accepted normally.
